// File: rtl/counter_share_pkg.sv
// rtl/counter_share_pkg.sv - shared state encoding and default widths for counter_share_ctrl
package counter_share_pkg;
   localparam int N_DEF    = 8;
   localparam int NREQ_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/counter_share_ctrl_arbiter.sv
// rtl/counter_share_ctrl_arbiter.sv - stateless round-robin pick starting at ptr
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_pick,
   output logic [IW-1:0]   o_idx,
   output logic            o_valid
);
   int w_j;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      o_pick  = '0;
      w_j     = 0;
      // first set bit at or above ptr, wrapping past NREQ-1
      for (int k = 0; k < NREQ; k++) begin
         w_j = (int'(i_ptr) + k) % NREQ;
         if (!o_valid && i_req[w_j]) begin
            o_valid = 1'b1;
            o_idx   = IW'(w_j);
         end
      end
      o_pick[o_idx] = o_valid;
   end
endmodule

// File: rtl/counter_share_ctrl.sv
// rtl/counter_share_ctrl.sv - round-robin owner of one shared up-counter
module counter_share_ctrl
   import counter_share_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] ld_val,
   input  logic              abort,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic [N-1:0]      count,
   output logic [NREQ-1:0]   done
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          r_state;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_done;
   logic            r_busy;
   logic [N-1:0]    r_count;
   logic [N-1:0]    r_tc;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_g;

   logic [NREQ-1:0] w_pick;
   logic [IW-1:0]   w_idx;
   logic            w_valid;
   logic [N-1:0]    w_count_inc;
   logic            w_release;
   logic [IW-1:0]   w_ptr_next;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_count_inc = r_count + 1'b1;
   assign w_release   = abort | ~req[r_g];
   assign w_ptr_next  = (r_g == IW'(NREQ - 1)) ? '0 : r_g + 1'b1;

   assign gnt   = r_gnt;
   assign busy  = r_busy;
   assign count = r_count;
   assign done  = r_done;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
         r_count <= '0;
         r_tc    <= '0;
         r_ptr   <= '0;
         r_g     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_gnt   <= w_pick;
                  r_g     <= w_idx;
                  r_tc    <= ld_val[int'(w_idx)*N +: N];
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_ptr_next;
                  r_state <= ST_IDLE;
               end else if (r_tc == '0) begin
                  r_done  <= r_gnt;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               // release beats terminal detect on the same edge
               if (w_release) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_ptr_next;
                  r_state <= ST_IDLE;
               end else begin
                  r_count <= w_count_inc;
                  if (w_count_inc == r_tc) begin
                     r_done  <= r_gnt;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= '0;
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb/tb_counter_share_ctrl.sv - directed plus random checks of counter_share_ctrl
module tb_counter_share_ctrl;
   localparam int N    = 8;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              clr;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] ld_val;
   logic              abort;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic [N-1:0]      count;
   logic [NREQ-1:0]   done;

   int n_cmp = 0;
   int n_err = 0;
   int m_ptr = 0;

   counter_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
      .clk    (clk),
      .clr    (clr),
      .req    (req),
      .ld_val (ld_val),
      .abort  (abort),
      .gnt    (gnt),
      .busy   (busy),
      .count  (count),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] rq, input int p);
      for (int k = 0; k < NREQ; k++)
         if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"},  32'(gnt),  32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // kind: 0 none, 1 abort, 2 drop req[g], 3 async reset; applied in cycle stop_k after grant
   task automatic txn(input logic [3:0] rq, input logic [31:0] lv, input int stop_k,
                      input int kind, input bit wiggle);
      int g, tc;
      logic [3:0] oh;
      req = rq; ld_val = lv; abort = 1'b0;
      g  = pick(rq, m_ptr);
      tc = int'(lv[g*N +: N]);
      oh = 4'(1 << g);
      @(posedge clk); @(negedge clk);
      for (int k = 0; k <= tc + 1; k++) begin
         chk("gnt",   32'(gnt),   32'(oh));
         chk("busy",  32'(busy),  32'd1);
         chk("count", 32'(count), 32'((k == 0) ? 0 : k - 1));
         chk("done",  32'(done),  (k == tc + 1) ? 32'(oh) : 32'd0);
         if (wiggle) req = 4'($urandom) | oh;
         if (k == stop_k && k <= tc && kind != 0) begin
            if (kind == 3) begin
               clr = 1'b0;
               #1;
               chk_idle("rst");
               chk("rst_count", 32'(count), 32'd0);
               req = '0;
               @(negedge clk);
               clr = 1'b1;
               m_ptr = 0;
               @(posedge clk); @(negedge clk);
               chk_idle("post_rst");
               return;
            end
            if (kind == 1) abort = 1'b1;
            else req[g] = 1'b0;
            @(posedge clk); @(negedge clk);
            abort = 1'b0;
            chk_idle("abort");
            m_ptr = (g + 1) % NREQ;
            return;
         end
         if (k == stop_k && kind == 1) abort = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      abort = 1'b0;
      chk_idle("end");
      chk("end_count", 32'(count), 32'(tc));
      m_ptr = (g + 1) % NREQ;
   endtask

   initial begin
      clr = 1'b0; req = '0; ld_val = '0; abort = 1'b0;
      #12;
      chk_idle("reset");
      chk("reset_count", 32'(count), 32'd0);
      @(negedge clk);
      clr = 1'b1;

      // reset mid-count at count=3 with owner 1 so ptr reset is observable
      txn(4'b0010, {4{8'd10}}, 4, 3, 1'b0);

      // abort in IDLE is ignored
      abort = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle("idle_abort");
      abort = 1'b0;

      // all requesters held: grant order 0,1,2,3,0 with one idle cycle each
      for (int i = 0; i < 5; i++) begin
         chk("rr_order", 32'(pick(4'b1111, m_ptr)), 32'(i % NREQ));
         txn(4'b1111, {4{8'd2}}, -1, 0, 1'b0);
      end

      txn(4'b0001, 32'h0000_0005, -1, 0, 1'b0);
      txn(4'b0100, 32'h0000_0000, -1, 0, 1'b0);

      // owner 0 aborted at count=3, next grant to requester 1
      chk("abort_owner", 32'(pick(4'b0011, m_ptr)), 32'd0);
      txn(4'b0011, {4{8'd10}}, 4, 1, 1'b0);
      chk("after_abort_owner", 32'(pick(4'b0011, m_ptr)), 32'd1);
      txn(4'b0011, {4{8'd3}}, -1, 0, 1'b0);

      // abort during DONE is ignored
      txn(4'b1000, {4{8'd4}}, 5, 1, 1'b0);

      // full-scale terminal count, then drop req mid-count
      txn(4'b1111, {4{8'hFF}}, -1, 0, 1'b0);
      txn(4'b1111, {4{8'd200}}, 50, 2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  rq;
         logic [31:0] lv;
         int          kind;
         rq = 4'($urandom_range(1, 15));
         for (int b = 0; b < NREQ; b++) lv[b*N +: N] = 8'($urandom_range(0, 9));
         kind = $urandom_range(0, 2);
         txn(rq, lv, (kind == 0) ? -1 : $urandom_range(0, 11), kind, 1'b1);
      end

      req = '0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
